// File: rtl/cd_mesh_pkg.sv
// Shared CD-mesh constants: LLC/link counts, index widths and the link index encoding.
package cd_mesh_pkg;

  localparam int CD_N_LLC      = 4;
  localparam int CD_N_LINK     = 8;
  localparam int CD_LINK_IDX_W = 3;
  localparam int CD_LLC_IDX_W  = 2;

  // Link index from mesh coordinates: 2*{sy[1],sx[1]} + sy[0].
  function automatic logic [CD_LINK_IDX_W-1:0] cd_link_idx(input logic [1:0] sx,
                                                           input logic [1:0] sy);
    return {sy[1], sx[1], sy[0]};
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority pick over 4 requesters, starting the search at ptr.
module rr_pick4
  import cd_mesh_pkg::*;
(
  input  logic [CD_N_LLC-1:0]     req,
  input  logic [CD_LLC_IDX_W-1:0] ptr,
  output logic [CD_N_LLC-1:0]     win,
  output logic [CD_LLC_IDX_W-1:0] idx,
  output logic                    any
);

  logic [CD_LLC_IDX_W-1:0] c0, c1, c2, c3;

  assign c0  = ptr;
  assign c1  = ptr + 2'd1;
  assign c2  = ptr + 2'd2;
  assign c3  = ptr + 2'd3;
  assign any = |req;

  always_comb begin
    idx = c3;
    if (req[c0])      idx = c0;
    else if (req[c1]) idx = c1;
    else if (req[c2]) idx = c2;
    win = any ? (4'b0001 << idx) : 4'b0000;
  end

endmodule

// File: rtl/cd_reply_sched_4x8.sv
// Reply-path scheduler: 4 LLC inputs onto 8 links, per-link round-robin with age-based urgency.
module cd_reply_sched_4x8
  import cd_mesh_pkg::*;
#(
  parameter int AGE_W   = 4,
  parameter int AGE_MAX = 15
)(
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CD_N_LLC-1:0]                 req_vld,
  input  logic [CD_N_LLC*CD_LINK_IDX_W-1:0]   req_tgt,
  input  logic [CD_N_LINK-1:0]                out_ro,
  output logic [CD_N_LLC-1:0]                 in_ri,
  output logic [CD_N_LINK-1:0]                out_so,
  output logic [CD_N_LINK*CD_N_LLC-1:0]       gnt,
  output logic [CD_N_LINK*CD_LLC_IDX_W-1:0]   sel,
  output logic [CD_N_LLC-1:0]                 urgent
);

  localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

  logic [CD_N_LINK-1:0][CD_LLC_IDX_W-1:0] ptr_q;
  logic [CD_N_LINK-1:0][CD_LLC_IDX_W-1:0] pick_idx;
  logic [AGE_W-1:0]                       age_q [CD_N_LLC];
  logic [CD_N_LLC-1:0]                    urg;

  assign urg[0] = (age_q[0] == AGE_SAT);
  assign urg[1] = (age_q[1] == AGE_SAT);
  assign urg[2] = (age_q[2] == AGE_SAT);
  assign urg[3] = (age_q[3] == AGE_SAT);
  assign urgent = reset ? '0 : urg;

  for (genvar o = 0; o < CD_N_LINK; o++) begin : g_out
    logic [CD_N_LLC-1:0]     req_col, u_win, a_win;
    logic [CD_LLC_IDX_W-1:0] u_idx, a_idx;
    logic                    u_any, a_any;

    for (genvar k = 0; k < CD_N_LLC; k++) begin : g_req
      assign req_col[k] = req_vld[k] &&
                          (req_tgt[CD_LINK_IDX_W*k +: CD_LINK_IDX_W] == CD_LINK_IDX_W'(o));
    end

    rr_pick4 u_pick_urg (.req(req_col & urg), .ptr(ptr_q[o]), .win(u_win), .idx(u_idx), .any(u_any));
    rr_pick4 u_pick_all (.req(req_col),       .ptr(ptr_q[o]), .win(a_win), .idx(a_idx), .any(a_any));

    // Urgent requesters pre-empt rotation whenever any of them targets this link.
    assign pick_idx[o] = u_any ? u_idx : a_idx;
    assign gnt[CD_N_LLC*o +: CD_N_LLC] = (out_ro[o] && !reset && a_any) ? (u_any ? u_win : a_win) : '0;
    assign out_so[o] = |gnt[CD_N_LLC*o +: CD_N_LLC];
    assign sel[CD_LLC_IDX_W*o +: CD_LLC_IDX_W] = out_so[o] ? pick_idx[o] : '0;
  end

  always_comb begin
    in_ri = '0;
    for (int o = 0; o < CD_N_LINK; o++) in_ri = in_ri | gnt[CD_N_LLC*o +: CD_N_LLC];
  end

  function automatic logic [AGE_W-1:0] age_next(input logic [AGE_W-1:0] a,
                                                input logic vld, input logic fire);
    if (!vld || fire)  return '0;
    if (a == AGE_SAT)  return a;
    return a + AGE_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      age_q[0] <= '0;
      age_q[1] <= '0;
      age_q[2] <= '0;
      age_q[3] <= '0;
    end else begin
      if (out_so[0]) ptr_q[0] <= pick_idx[0] + 2'd1;
      if (out_so[1]) ptr_q[1] <= pick_idx[1] + 2'd1;
      if (out_so[2]) ptr_q[2] <= pick_idx[2] + 2'd1;
      if (out_so[3]) ptr_q[3] <= pick_idx[3] + 2'd1;
      if (out_so[4]) ptr_q[4] <= pick_idx[4] + 2'd1;
      if (out_so[5]) ptr_q[5] <= pick_idx[5] + 2'd1;
      if (out_so[6]) ptr_q[6] <= pick_idx[6] + 2'd1;
      if (out_so[7]) ptr_q[7] <= pick_idx[7] + 2'd1;
      age_q[0] <= age_next(age_q[0], req_vld[0], in_ri[0]);
      age_q[1] <= age_next(age_q[1], req_vld[1], in_ri[1]);
      age_q[2] <= age_next(age_q[2], req_vld[2], in_ri[2]);
      age_q[3] <= age_next(age_q[3], req_vld[3], in_ri[3]);
    end
  end

endmodule

// File: tb/tb_cd_reply_sched_4x8.sv
// Randomized + directed bench for cd_reply_sched_4x8 against a rule-level arbitration model.
module tb_cd_reply_sched_4x8;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_vld;
  logic [11:0] req_tgt;
  logic [7:0]  out_ro;
  logic [3:0]  in_ri;
  logic [7:0]  out_so;
  logic [31:0] gnt;
  logic [15:0] sel;
  logic [3:0]  urgent;

  cd_reply_sched_4x8 dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_tgt(req_tgt), .out_ro(out_ro),
    .in_ri(in_ri), .out_so(out_so), .gnt(gnt), .sel(sel), .urgent(urgent)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  int ptr_m [8];
  int age_m [4];
  logic [3:0]  fired_m;
  logic [3:0]  prev_vld, prev_fire;
  logic [11:0] prev_tgt;
  logic        prev_reset;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int tgt_of(input int k);
    return int'(req_tgt[3*k +: 3]);
  endfunction

  // One clock: check outputs at negedge against the model, advance the model, return at posedge+1.
  task automatic cycle();
    logic [31:0] e_gnt;
    logic [15:0] e_sel;
    logic [7:0]  e_so;
    logic [3:0]  e_ri, e_urg;
    int          winner [8];
    @(negedge clk);
    e_gnt = '0; e_sel = '0; e_so = '0; e_ri = '0; e_urg = '0;
    for (int o = 0; o < 8; o++) begin
      bit have_urg = 0;
      bit found = 0;
      winner[o] = -1;
      if (!reset && out_ro[o]) begin
        for (int k = 0; k < 4; k++)
          if (req_vld[k] && tgt_of(k) == o && age_m[k] == 15) have_urg = 1;
        for (int i = 0; i < 4; i++) begin
          int k = (ptr_m[o] + i) % 4;
          if (!found && req_vld[k] && tgt_of(k) == o && (!have_urg || age_m[k] == 15)) begin
            found = 1;
            winner[o] = k;
          end
        end
      end
      if (winner[o] >= 0) begin
        e_gnt[4*o + winner[o]] = 1'b1;
        e_so[o] = 1'b1;
        e_ri[winner[o]] = 1'b1;
        e_sel[2*o +: 2] = 2'(winner[o]);
      end
    end
    if (!reset) for (int k = 0; k < 4; k++) e_urg[k] = (age_m[k] == 15);

    chk("gnt", gnt, e_gnt);
    chk("sel", {16'h0, sel}, {16'h0, e_sel});
    chk("out_so", {24'h0, out_so}, {24'h0, e_so});
    chk("in_ri", {28'h0, in_ri}, {28'h0, e_ri});
    chk("urgent", {28'h0, urgent}, {28'h0, e_urg});

    for (int k = 0; k < 4; k++)
      if (!prev_reset && !reset && prev_vld[k] && !prev_fire[k])
        assert (req_vld[k] && req_tgt[3*k +: 3] == prev_tgt[3*k +: 3])
          else $error("protocol violation on input %0d", k);
    prev_vld = req_vld; prev_tgt = req_tgt; prev_fire = e_ri; prev_reset = reset;

    if (reset) begin
      for (int o = 0; o < 8; o++) ptr_m[o] = 0;
      for (int k = 0; k < 4; k++) age_m[k] = 0;
    end else begin
      for (int o = 0; o < 8; o++) if (winner[o] >= 0) ptr_m[o] = (winner[o] + 1) % 4;
      for (int k = 0; k < 4; k++)
        if (!req_vld[k] || e_ri[k]) age_m[k] = 0;
        else if (age_m[k] < 15)     age_m[k] = age_m[k] + 1;
    end
    fired_m = e_ri;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_vld = '0; req_tgt = '0; out_ro = '0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic random_traffic(input int n, input bit narrow);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < 4; k++)
        if (!req_vld[k] || fired_m[k]) begin
          req_vld[k] = 1'($urandom_range(0, 3) != 0);
          req_tgt[3*k +: 3] = narrow ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
        end
      out_ro = narrow ? 8'($urandom & $urandom & $urandom) : 8'($urandom);
      cycle();
    end
  endtask

  initial begin
    prev_vld = '0; prev_tgt = '0; prev_fire = '0; prev_reset = 1'b1; fired_m = '0;
    for (int o = 0; o < 8; o++) ptr_m[o] = 0;
    for (int k = 0; k < 4; k++) age_m[k] = 0;

    do_reset();
    // All inputs to link 0: grants rotate 0,1,2,3,0.
    req_vld = 4'hF; req_tgt = '0; out_ro = 8'hFF;
    #1 chk("rot_first_gnt", gnt, 32'h1);
    chk("rot_first_ri", {28'h0, in_ri}, 32'h1);
    repeat (8) cycle();

    do_reset();
    req_vld = 4'hF; req_tgt = {3'd7, 3'd5, 3'd2, 3'd0}; out_ro = 8'hFF;
    #1 chk("spread_so", {24'h0, out_so}, 32'hA5);
    chk("spread_ri", {28'h0, in_ri}, 32'hF);
    cycle();
    req_vld = '0;
    cycle();

    // Inputs 1 and 2 stall on link 3, then drain in pointer order.
    do_reset();
    req_vld = 4'b0110; req_tgt = {3'd0, 3'd3, 3'd3, 3'd0}; out_ro = 8'h00;
    repeat (20) cycle();
    chk("stall_urgent", {28'h0, urgent}, 32'h6);
    out_ro = 8'h08;
    #1 chk("stall_win1", {30'h0, sel[7:6]}, 32'd1);
    cycle();
    req_vld = 4'b0100;
    #1 chk("stall_win2", {30'h0, sel[7:6]}, 32'd2);
    cycle();
    req_vld = '0;
    cycle();

    // Urgent input 3 beats input 0 even though ptr[4] favours 0.
    do_reset();
    req_vld = 4'b1000; req_tgt = {3'd4, 3'd0, 3'd0, 3'd0}; out_ro = 8'h00;
    repeat (16) cycle();
    req_vld = 4'b1001; req_tgt = {3'd4, 3'd0, 3'd0, 3'd4};
    cycle();
    out_ro = 8'h10;
    #1 chk("urg_beats_ptr", {30'h0, sel[9:8]}, 32'd3);
    repeat (3) cycle();

    // Saturation: age holds at 15 for a long stall.
    do_reset();
    req_vld = 4'b0100; req_tgt = {3'd0, 3'd6, 3'd0, 3'd0}; out_ro = 8'h00;
    repeat (30) cycle();
    chk("sat_urgent", {28'h0, urgent}, 32'h4);
    out_ro = 8'h40;
    cycle();
    req_vld = '0;
    cycle();

    // Reset mid-burst while grants are live.
    do_reset();
    random_traffic(200, 1'b1);
    req_vld = 4'hF; req_tgt = '0; out_ro = 8'hFF;
    reset = 1'b1;
    #1 chk("midrst_gnt", gnt, 32'h0);
    cycle();
    reset = 1'b0;
    #1 chk("postrst_gnt", gnt, 32'h1);
    cycle();

    random_traffic(1500, 1'b1);
    random_traffic(1500, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
